// File: rtl/fp_pair_unpack.sv
// fp_pair_unpack: pops binary32 words from a first-word-fall-through FIFO in
// pairs (A then B), unpacks each into sign/exponent/significand/class and holds
// the registered pair for a valid/ready consumer. Single clock domain (rclk).
module fp_pair_unpack #(
  parameter int unsigned DSIZE = 32
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_sign,
  output logic [7:0]       a_exp,
  output logic [23:0]      a_man,
  output logic [3:0]       a_class,
  output logic             b_sign,
  output logic [7:0]       b_exp,
  output logic [23:0]      b_man,
  output logic [3:0]       b_class,
  output logic [15:0]      pair_cnt
);

  typedef enum logic [1:0] {StA, StB, StOut} state_e;

  state_e state_q;

  logic        u_sign;
  logic [7:0]  u_exp;
  logic [23:0] u_man;
  logic [3:0]  u_class;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;

  // Pop only while collecting a pair; never during reset or while holding.
  always_comb begin
    rd = ~rrst & ~rempty & ((state_q == StA) | (state_q == StB));
  end

  // Unpack the FIFO head word; class is {nan, inf, zero, denorm}.
  always_comb begin
    w_exp   = rdata[30:23];
    w_frac  = rdata[22:0];
    u_sign  = rdata[31];
    u_exp   = w_exp;
    u_man   = {1'b1, w_frac};
    u_class = 4'b0000;
    if (w_exp == 8'h00) begin
      u_man = {1'b0, w_frac};
      if (w_frac == 23'd0) begin
        u_exp   = 8'h00;
        u_class = 4'b0010;
      end else begin
        // Denormals share the scale of exponent 1.
        u_exp   = 8'h01;
        u_class = 4'b0001;
      end
    end else if (w_exp == 8'hFF) begin
      u_class = (w_frac == 23'd0) ? 4'b0100 : 4'b1000;
    end
  end

  // Pair-collection FSM with registered outputs.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q   <= StA;
      out_valid <= 1'b0;
      a_sign    <= 1'b0;
      a_exp     <= 8'h00;
      a_man     <= 24'h000000;
      a_class   <= 4'b0000;
      b_sign    <= 1'b0;
      b_exp     <= 8'h00;
      b_man     <= 24'h000000;
      b_class   <= 4'b0000;
      pair_cnt  <= 16'h0000;
    end else begin
      unique case (state_q)
        StA: begin
          if (rd) begin
            a_sign  <= u_sign;
            a_exp   <= u_exp;
            a_man   <= u_man;
            a_class <= u_class;
            state_q <= StB;
          end
        end
        StB: begin
          if (rd) begin
            b_sign    <= u_sign;
            b_exp     <= u_exp;
            b_man     <= u_man;
            b_class   <= u_class;
            out_valid <= 1'b1;
            state_q   <= StOut;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pair_cnt  <= pair_cnt + 16'd1;
            state_q   <= StA;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_q   <= StA;
        end
      endcase
    end
  end

endmodule
